// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave; the grant is held for a whole cyc.
// Optional WB_ARB_TIMEOUT_EN adds a stalled-strobe watchdog that answers with a one-cycle err.
module wb_rr_arbiter #(
  parameter int unsigned NM = 2,
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32,
  parameter int unsigned TO = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [NM*aw-1:0]  m_adr_i,
  input  logic [NM*dw-1:0]  m_dat_i,
  input  logic [NM*4-1:0]   m_sel_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM*3-1:0]   m_cti_i,
  input  logic [NM*2-1:0]   m_bte_i,
  output logic [dw-1:0]     m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic [NM-1:0]     m_rty_o,
  output logic [aw-1:0]     s_adr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [dw-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [NM-1:0]     grant_o
);

  localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;

  if (NM < 2 || NM > 8) begin : g_bad_nm
    $error("wb_rr_arbiter: NM must be 2..8");
  end
  if (TO < 1 || TO > 65535) begin : g_bad_to
    $error("wb_rr_arbiter: TO must be 1..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic          busy;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          to_c;

  assign busy = (state == BUSY);

  // First requester after the last winner, wrapping modulo NM
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NM; i++) begin
      cand = PW'((32'(ptr) + i) % NM);
      if (!win_found && m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= PW'(NM - 1);
    end else begin
      case (state)
        IDLE: if (win_found) begin
          state   <= BUSY;
          grant_o <= NM'(1) << win_idx;
          ptr     <= win_idx;
        end
        BUSY: if (!m_cyc_i[ptr]) begin
          state   <= IDLE;
          grant_o <= '0;
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

  // Slave-side mux driven by the registered one-hot grant; all zero while idle
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (busy && grant_o[i]) begin
        s_adr_o = m_adr_i[i*aw +: aw];
        s_dat_o = m_dat_i[i*dw +: dw];
        s_sel_o = m_sel_i[i*4 +: 4];
        s_we_o  = m_we_i[i];
        s_cyc_o = m_cyc_i[i];
        s_stb_o = m_stb_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
      end
    end
  end

  assign m_dat_o = busy ? s_dat_i : '0;
  assign m_ack_o = grant_o & {NM{s_ack_i & ~to_c}};
  assign m_err_o = grant_o & {NM{s_err_i | to_c}};
  assign m_rty_o = grant_o & {NM{s_rty_i & ~to_c}};

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        resp;

  assign resp = s_ack_i | s_err_i | s_rty_i;
  // Fires on the TO-th consecutive unanswered strobe cycle
  assign to_c = busy && s_stb_o && !resp && (to_cnt == 16'(TO - 1));

  always_ff @(posedge wb_clk) begin
    if (wb_rst || !busy || !s_stb_o || resp || to_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_c = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NM=4, TO=8) with a word-addressed slave memory model.
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 8;

  logic             wb_clk = 1'b0;
  logic             wb_rst;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o, s_dat_i;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic             slave_en;
  logic [31:0]      mem [16];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd_q [$];
  int          gnt_q [$];

  always #5 wb_clk = ~wb_clk;

  wb_rr_arbiter #(.NM(NM), .dw(DW), .aw(AW), .TO(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  // Zero-wait slave: acks every strobe while enabled
  assign s_ack_i = slave_en & s_cyc_o & s_stb_o;
  assign s_err_i = 1'b0;
  assign s_rty_i = 1'b0;
  assign s_dat_i = mem[s_adr_o[5:2]];

  always @(posedge wb_clk) begin
    if (s_ack_i && s_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (s_sel_o[b]) mem[s_adr_o[5:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk);
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc_i[i]           = cyc;
    m_stb_i[i]           = stb;
    m_we_i[i]            = we;
    m_adr_i[i*AW +: AW]  = adr;
    m_dat_i[i*DW +: DW]  = dat;
    m_sel_i[i*4 +: 4]    = 4'hF;
    m_cti_i[i*3 +: 3]    = cti;
    m_bte_i[i*2 +: 2]    = 2'b00;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    tick();
    tick();
    wb_rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int k;
    k = 0;
    while (grant_o == '0 && k < 16) begin
      tick();
      #1;
      k++;
    end
    chk({tag, "_granted"}, 64'(grant_o != '0), 64'(1));
  endtask

  initial begin
    int exp_g;
    int g;
    int ack0, ack1, errs, err_at;
    logic [NM-1:0] err_vec;
    logic [NM-1:0] onehot;

    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    wb_rst = 1'b1; slave_en = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;

    // Reset with both masters already requesting
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 3'b000);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 3'b000);
    tick(); tick(); #1;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("rst_s_adr", 64'(s_adr_o), 64'(0));
    chk("rst_m_dat", 64'(m_dat_o), 64'(0));
    chk("rst_m_ack", 64'(m_ack_o), 64'(0));
    tick();
    wb_rst = 1'b0; slave_en = 1'b1;
    rd_q.push_back(32'hDEAD_BEEF);
    tick(); #1;
    chk("m0_grant", 64'(grant_o), 64'(4'b0001));
    chk("m0_s_cyc", 64'(s_cyc_o), 64'(1));
    chk("m0_s_we", 64'(s_we_o), 64'(1));
    chk("m0_s_adr", 64'(s_adr_o), 64'(32'h4));
    chk("m0_s_dat", 64'(s_dat_o), 64'(32'hDEAD_BEEF));
    chk("m0_ack_only", 64'(m_ack_o), 64'(4'b0001));
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    chk("m0_rel_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("m0_rel_grant", 64'(grant_o), 64'(4'b0001));
    tick(); #1;
    chk("gap_grant", 64'(grant_o), 64'(0));
    tick(); #1;
    chk("m1_grant", 64'(grant_o), 64'(4'b0010));
    chk("m1_ack", 64'(m_ack_o), 64'(4'b0010));
    chk("m1_rdata", 64'(m_dat_o), 64'(rd_q.pop_front()));
    tick();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // All four request continuously; each releases after one access
    do_reset();
    for (int i = 0; i < 5; i++) gnt_q.push_back(i % NM);
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 3'b000);
    #1;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rr");
      exp_g  = gnt_q.pop_front();
      onehot = NM'(1) << exp_g;
      chk("rr_grant", 64'(grant_o), 64'(onehot));
      chk("rr_ack", 64'(m_ack_o), 64'(onehot));
      g = 0;
      for (int b = 0; b < NM; b++) if (grant_o[b]) g = b;
      tick();
      set_m(g, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      #1;
      chk("rr_rel_s_cyc", 64'(s_cyc_o), 64'(0));
      tick();
      set_m(g, 1'b1, 1'b1, 1'b0, 32'(g * 4), 32'h0, 3'b000);
      #1;
      chk("rr_gap", 64'(grant_o), 64'(0));
    end
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // M0 10-beat incrementing burst while M1 waits
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010);
    tick(); #1;
    chk("burst_grant0", 64'(grant_o), 64'(4'b0001));
    chk("burst_cti", 64'(s_cti_o), 64'(3'b010));
    set_m(1, 1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 3'b000);
    ack0 = 0; ack1 = 0;
    for (int beat = 0; beat < 10; beat++) begin
      if (beat > 0) begin
        tick(); #1;
      end
      chk("burst_hold", 64'(grant_o), 64'(4'b0001));
      ack0 += int'(m_ack_o[0]);
      ack1 += int'(m_ack_o[1]);
    end
    chk("burst_acks_m0", 64'(ack0), 64'(10));
    chk("burst_acks_m1", 64'(ack1), 64'(0));
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    chk("burst_rel_grant", 64'(grant_o), 64'(4'b0001));
    tick(); #1;
    chk("burst_gap", 64'(grant_o), 64'(0));
    tick(); #1;
    chk("burst_m1_grant", 64'(grant_o), 64'(4'b0010));

    // Reset while M1 owns the bus and M0 is requesting
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    #1;
    chk("busy_rst_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("busy_rst_grant", 64'(grant_o), 64'(0));
    chk("busy_rst_ack", 64'(m_ack_o), 64'(0));
    tick(); #1;
    chk("post_rst_grant", 64'(grant_o), 64'(4'b0001));

    // M0 releases and re-requests alone
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    chk("regain_gap", 64'(grant_o), 64'(0));
    tick(); #1;
    chk("regain_grant", 64'(grant_o), 64'(4'b0001));

    // Silent slave: M2 strobes without ever being answered
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    slave_en = 1'b0;
    tick();
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
    tick(); #1;
    chk("stall_grant", 64'(grant_o), 64'(4'b0100));
    errs = 0; err_at = 0; err_vec = '0;
    for (int c = 1; c <= 12; c++) begin
      if (m_err_o != '0) begin
        errs++;
        err_at  = c;
        err_vec = m_err_o;
      end
      tick(); #1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("to_err_count", 64'(errs), 64'(1));
    chk("to_err_cycle", 64'(err_at), 64'(TO));
    chk("to_err_target", 64'(err_vec), 64'(4'b0100));
    chk("to_grant_held", 64'(grant_o), 64'(4'b0100));
`else
    chk("no_to_err_count", 64'(errs), 64'(0));
    chk("no_to_grant_held", 64'(grant_o), 64'(4'b0100));
`endif
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick(); #1;
    chk("final_rel_s_cyc", 64'(s_cyc_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
